// File: rtl/arb_14_2_1_pkg.sv
// Shared definitions for the 14-bit 2:1 arbiter slice: source encodings,
// output-register state encoding and datapath width.
package arb_14_2_1_pkg;

  localparam int DATA_W = 14;

  // Source identifiers as carried on out_src and on the mux select.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Width of the burst counter; wide enough for BURST up to 15.
  localparam int BURST_W = 4;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Increment that sticks at the all-ones value of a CNT_W-bit counter
  // (value passed in 16 bits; callers truncate back to their width).
  function automatic logic [15:0] sat_inc(input logic [15:0] val,
                                          input logic [15:0] max_val);
    if (val >= max_val) begin
      return max_val;
    end
    return val + 16'd1;
  endfunction

endpackage

// File: rtl/arb_14_2_1_mux.sv
// Plain 2:1 word mux feeding the output data register. s=0 selects a.
module mux_14_2_1
  import arb_14_2_1_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              s,
  output logic [DATA_W-1:0] res
);

  // Select between the two source words.
  always_comb begin
    res = a;
    if (s == SRC_B) begin
      res = b;
    end
  end

endmodule

// File: rtl/arb_14_2_1.sv
// Two-requester arbiter and output-register sequencer for the shared 14-bit
// datapath. One word per cycle is granted (A or B), muxed, and captured in a
// one-entry output register with its own valid/ready port.
//
// Output register FSM:
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | output register holds nothing, out_valid=0
//   ST_FULL  | output register holds a word,  out_valid=1
//
// Fairness: a source keeps the grant while the other is waiting for at most
// BURST consecutive handshakes; a lone requester is never throttled.
module arb_14_2_1
  import arb_14_2_1_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  a_cnt,
  output logic [CNT_W-1:0]  b_cnt
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  out_state_t         state_q;
  out_state_t         state_d;
  logic               last_src;
  logic [BURST_W-1:0] burst_cnt;
  logic               grant;
  logic               load_en;
  logic               hs;
  logic [DATA_W-1:0]  mux_res;

  assign out_valid = (state_q == ST_FULL);

  // The register can take a new word when empty or when it drains this cycle.
  assign load_en = !out_valid || out_ready;

  // Grant selection; with no requester the select parks on last_src.
  always_comb begin
    grant = last_src;
    if (a_valid && !b_valid) begin
      grant = SRC_A;
    end else if (b_valid && !a_valid) begin
      grant = SRC_B;
    end else if (a_valid && b_valid) begin
      if (burst_cnt < BURST_MAX) begin
        grant = last_src;
      end else begin
        grant = ~last_src;
      end
    end
  end

  // Readies; rst_n gating keeps both low while reset is asserted, since the
  // reset-cleared register would otherwise look ready to load.
  always_comb begin
    a_ready = rst_n && load_en && a_valid && (grant == SRC_A);
    b_ready = rst_n && load_en && b_valid && (grant == SRC_B);
    hs      = a_ready || b_ready;
  end

  mux_14_2_1 u_mux (
    .a   (a_data),
    .b   (b_data),
    .s   (grant),
    .res (mux_res)
  );

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: load wins over drain, so drain+load stays FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (hs) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready && !hs) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Capture the granted word and its origin on every handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= SRC_A;
    end else if (hs) begin
      out_data <= mux_res;
      out_src  <= grant;
    end
  end

  // Burst tracking: consecutive handshakes to the same source, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_src  <= SRC_A;
      burst_cnt <= '0;
    end else if (hs) begin
      if (grant == last_src) begin
        if (burst_cnt < BURST_MAX) begin
          burst_cnt <= burst_cnt + 1'b1;
        end
      end else begin
        last_src  <= grant;
        burst_cnt <= BURST_W'(1);
      end
    end
  end

  // Per-source accepted-beat counters; clear beats a coincident handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else if (clr_cnt) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_ready) begin
        a_cnt <= CNT_W'(sat_inc(16'(a_cnt), 16'(CNT_MAX)));
      end
      if (b_ready) begin
        b_cnt <= CNT_W'(sat_inc(16'(b_cnt), 16'(CNT_MAX)));
      end
    end
  end

endmodule

// File: tb/tb_arb_14_2_1.sv
// Directed bench for arb_14_2_1. Two instances share all inputs: u_dut with
// the default CNT_W=8 and u_dut4 with CNT_W=4 for counter saturation.
module tb_arb_14_2_1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, out_ready, clr_cnt;
  logic [13:0] a_data, b_data;
  logic        a_ready, b_ready, out_valid, out_src;
  logic [13:0] out_data;
  logic [7:0]  a_cnt, b_cnt;
  logic        a_ready4, b_ready4, out_valid4, out_src4;
  logic [13:0] out_data4;
  logic [3:0]  a_cnt4, b_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arb_14_2_1 #(.BURST(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .clr_cnt(clr_cnt),
    .a_cnt(a_cnt), .b_cnt(b_cnt)
  );

  arb_14_2_1 #(.BURST(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_src(out_src4),
    .out_ready(out_ready), .clr_cnt(clr_cnt),
    .a_cnt(a_cnt4), .b_cnt(b_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 0; b_valid = 0; out_ready = 0; clr_cnt = 0;
    a_data = '0; b_data = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cnt", {a_cnt, b_cnt}, 0);
    rst_n = 1'b1;
    tick();

    // 1: asynchronous reset in the middle of a stall.
    a_valid = 1; a_data = 14'h2A5A; out_ready = 0;
    tick();
    a_valid = 1; a_data = 14'h0111;
    #1;
    chk("t1_full", out_valid, 1);
    chk("t1_data", out_data, 14'h2A5A);
    chk("t1_stall_ready", {a_ready, b_ready}, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", out_valid, 0);
    chk("t1_rst_data", out_data, 0);
    chk("t1_rst_src", out_src, 0);
    chk("t1_rst_ready", {a_ready, b_ready}, 0);
    chk("t1_rst_cnt", {a_cnt, b_cnt}, 0);
    a_valid = 0;
    rst_n = 1'b1;
    tick();

    // 2: A alone, 8 back-to-back beats.
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1; a_data = 14'h1ABC + 14'(i);
      #1;
      chk("t2_a_ready", a_ready, 1);
      tick();
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, 14'h1ABC + 14'(i));
      chk("t2_src", out_src, 0);
    end
    a_valid = 0;
    chk("t2_a_cnt", a_cnt, 8);

    // 3: both always valid, BURST=4 alternation.
    do_reset();
    a_valid = 1; b_valid = 1; a_data = 14'h0AAA; b_data = 14'h0BBB; out_ready = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t3_src", out_src, ((k / 4) % 2));
      chk("t3_data", out_data, ((k / 4) % 2) ? 14'h0BBB : 14'h0AAA);
    end
    chk("t3_a_cnt", a_cnt, 8);
    chk("t3_b_cnt", b_cnt, 8);
    chk("t3_a_cnt4", a_cnt4, 8);

    // 4: stall 3 cycles while FULL, then drain+load together.
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_ready", {a_ready, b_ready}, 0);
      tick();
      chk("t4_stable_data", out_data, 14'h0BBB);
      chk("t4_stable_src", out_src, 1);
    end
    out_ready = 1;
    #1;
    chk("t4_load_a_ready", a_ready, 1);
    tick();
    chk("t4_valid", out_valid, 1);
    chk("t4_data", out_data, 14'h0AAA);
    chk("t4_src", out_src, 0);

    // 5: B alone for 10 beats, then A arrives and wins immediately.
    do_reset();
    a_valid = 0; b_valid = 1; out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t5_b_ready", b_ready, 1);
      tick();
    end
    chk("t5_b_cnt", b_cnt, 10);
    a_valid = 1;
    #1;
    chk("t5_a_wins", {a_ready, b_ready}, 2'b10);
    tick();
    chk("t5_src", out_src, 0);
    #1;
    chk("t5_burst_restart", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 0; b_valid = 0;

    // 6: counter saturation at CNT_W=4 and clear priority.
    do_reset();
    a_valid = 1; a_data = 14'h0005; out_ready = 1;
    for (int k = 0; k < 20; k++) tick();
    chk("t6_a_cnt4_sat", a_cnt4, 15);
    chk("t6_a_cnt8", a_cnt, 20);
    clr_cnt = 1;
    #1;
    chk("t6_clr_hs", a_ready, 1);
    tick();
    chk("t6_clr_a_cnt", a_cnt, 0);
    chk("t6_clr_a_cnt4", a_cnt4, 0);
    clr_cnt = 0;
    tick();
    chk("t6_after_clr", a_cnt, 1);
    a_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
